// File: rtl/dual_ram_pkg.sv
// dual_ram shared constants and types.
// Default geometry: 16 words of 8 bits.
package dual_ram_pkg;

  localparam int DUAL_RAM_WIDTH = 8;
  localparam int DUAL_RAM_DEPTH = 16;
  localparam int DUAL_RAM_ADDR  = 4;

  typedef logic [DUAL_RAM_WIDTH-1:0] word_t;

endpackage

// File: rtl/dual_ram_if.sv
// Storage-side bus of dual_ram: write port plus
// an unregistered read of the addressed word.
interface dual_ram_if
  import dual_ram_pkg::*;
#(
  parameter int width = DUAL_RAM_WIDTH,
  parameter int addr  = DUAL_RAM_ADDR
);

  logic [width-1:0] din;
  logic [addr-1:0]  wr_addr;
  logic             we;
  logic [addr-1:0]  rd_addr;
  logic [width-1:0] rdata;

  modport master (
    output din,
    output wr_addr,
    output we,
    output rd_addr,
    input  rdata
  );

  modport slave (
    input  din,
    input  wr_addr,
    input  we,
    input  rd_addr,
    output rdata
  );

endinterface

// File: rtl/dual_ram_array.sv
// Storage array with write port and async clear.
// rdata shows pre-edge contents, giving read-first.
module dual_ram_array
  import dual_ram_pkg::*;
#(
  parameter int width = DUAL_RAM_WIDTH,
  parameter int depth = DUAL_RAM_DEPTH,
  parameter int addr  = DUAL_RAM_ADDR
) (
  input logic      clk,
  input logic      rst,
  dual_ram_if.slave bus
);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];

  always_comb begin
    mem_d = mem_q;
    if (bus.we) mem_d[bus.wr_addr] = bus.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  assign bus.rdata = mem_q[bus.rd_addr];

endmodule

// File: rtl/dual_ram.sv
// Simple dual-port synchronous RAM, top level.
// Registered read port with enable and hold.
module dual_ram
  import dual_ram_pkg::*;
#(
  parameter int width = DUAL_RAM_WIDTH,
  parameter int depth = DUAL_RAM_DEPTH,
  parameter int addr  = DUAL_RAM_ADDR
) (
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  input  logic [addr-1:0]  wr_addr,
  input  logic [addr-1:0]  rd_addr,
  input  logic             we,
  input  logic             re,
  input  logic             clk,
  input  logic             rst
);

  dual_ram_if #(.width(width), .addr(addr)) bus ();

  assign bus.din     = din;
  assign bus.wr_addr = wr_addr;
  assign bus.we      = we;
  assign bus.rd_addr = rd_addr;

  dual_ram_array #(
    .width(width),
    .depth(depth),
    .addr (addr)
  ) u_array (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [width-1:0] dout_q;
  logic [width-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (re) dout_d = bus.rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= '0;
    else      dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_dual_ram.sv
// Directed bench for dual_ram with a reference
// memory model and an expected-dout queue.
module tb_dual_ram;
  import dual_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic re  = 1'b0;

  dual_ram_if bus ();

  dual_ram dut (
    .din    (bus.din),
    .dout   (bus.rdata),
    .wr_addr(bus.wr_addr),
    .rd_addr(bus.rd_addr),
    .we     (bus.we),
    .re     (re),
    .clk    (clk),
    .rst    (rst)
  );

  always #5 clk = ~clk;

  word_t mdl [DUAL_RAM_DEPTH];
  word_t last;
  word_t exp_q [$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input word_t exp);
    checks++;
    assert (bus.rdata === exp) else begin
      errors++;
      $error("FAIL %s: dout=%h expected=%h",
             tag, bus.rdata, exp);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < DUAL_RAM_DEPTH; i++)
      mdl[i] = '0;
    last = '0;
  endtask

  // One clock cycle: drive on negedge, check after posedge.
  task automatic cyc(input string tag,
                     input logic w, input int wa,
                     input word_t d,
                     input logic r, input int ra);
    word_t e;
    @(negedge clk);
    bus.we      = w;
    bus.wr_addr = wa[3:0];
    bus.din     = d;
    re          = r;
    bus.rd_addr = ra[3:0];
    if (r) last = mdl[ra];
    exp_q.push_back(last);
    if (w) mdl[wa] = d;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, e);
  endtask

  initial begin
    bus.we = 1'b0;
    bus.din = '0;
    bus.wr_addr = '0;
    bus.rd_addr = '0;
    clr_model();
    @(posedge clk);
    #1;
    check("reset_dout", '0);
    @(negedge clk);
    rst = 1'b1;
    cyc("post_reset_rd", 0, 0, 8'h00, 1, 11);

    for (int x = 0; x < 16; x++)
      cyc("fill", 1, x, word_t'(8'hA0 + x), 0, 0);
    for (int y = 0; y < 16; y++)
      cyc("readback", 0, 0, 8'h00, 1, y);

    cyc("we_off", 0, 3, 8'hFF, 0, 0);
    cyc("we_off_rd", 0, 0, 8'h00, 1, 3);

    cyc("hold_rd5", 0, 0, 8'h00, 1, 5);
    for (int k = 0; k < 3; k++)
      cyc("hold", 0, 0, 8'h00, 0, 9);
    cyc("hold_rd9", 0, 0, 8'h00, 1, 9);

    cyc("rd7_pre", 0, 0, 8'h00, 1, 7);
    cyc("collide", 1, 7, 8'h3C, 1, 7);
    cyc("collide_next", 0, 0, 8'h00, 1, 7);
    cyc("diff_addr", 1, 2, 8'h5A, 1, 12);
    cyc("diff_rd", 0, 0, 8'h00, 1, 2);

    // Async clear between edges while a read is active.
    cyc("pre_arst", 0, 0, 8'h00, 1, 14);
    @(negedge clk);
    re = 1'b1;
    bus.we = 1'b1;
    bus.wr_addr = 4'd1;
    bus.din = 8'h77;
    #2;
    rst = 1'b0;
    #1;
    check("arst_immediate", '0);
    clr_model();
    @(posedge clk);
    #1;
    check("arst_held", '0);
    @(negedge clk);
    rst = 1'b1;
    bus.we = 1'b0;
    for (int y = 0; y < 16; y++)
      cyc("post_arst_rd", 0, 0, 8'h00, 1, y);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
